btb_update_unit: RTL and testbench
==================================

# btb_update_unit

Resolution-side companion to the branch target buffer. It carries each IF-stage prediction (PC, hit, predicted target) down a private IF→ID→EX tracking pipeline. It compares that prediction with the outcome resolved in EX, and on a mismatch drives the pipeline redirect/flush and a registered write into the BTB. It also keeps branch and mispredict statistics counters.

## Interface

Parameters:
- `IDX_W`, default 6: BTB index width, giving 64 entries. Index is `pc[IDX_W+1:2]`; tag is `pc[31:IDX_W+2]`.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `if_valid`, in, 1: IF holds a real instruction this cycle.
- `if_pc`, in, 32: PC looked up in the BTB this cycle.
- `if_hit`, in, 1: BTB hit, meaning the BTB predicted taken.
- `if_pred_pc`, in, 32: PC the BTB selected as next PC.
- `stall`, in, 1: hazard unit freezes IF/ID and ID/EX.
- `ex_is_br`, in, 1: the EX instruction is a conditional branch or jal.
- `ex_taken`, in, 1: resolved direction.
- `ex_target`, in, 32: resolved taken target.
- `redirect`, out, 1: mispredict this cycle; flush IF/ID and ID/EX.
- `redirect_pc`, out, 32: correct next PC. Valid only when `redirect`.
- `upd_we`, out, 1: BTB write strobe, one cycle.
- `upd_idx`, out, IDX_W: entry index.
- `upd_tag`, out, 32-IDX_W-2: entry tag.
- `upd_target`, out, 32: entry target.
- `upd_valid`, out, 1: 1 allocates or overwrites the entry; 0 invalidates it.
- `br_cnt`, out, CNT_W: resolved branches.
- `mis_cnt`, out, CNT_W: mispredicts.

## Operation

- Tracking slots ID and EX each hold {v, pc, hit, pred_pc}.
  - When `stall`=0, each clock shifts IF→ID→EX.
  - When `stall`=1, both slots hold.
  - When `redirect`=1, both slots load v=0 on the next edge, overriding the shift.
- Resolution is evaluated only when EX.v=1 and `stall`=0. With `pc4` = EX.pc+4, the cases are:
  - Non-branch, hit (alias): mispredict. `redirect_pc`=pc4. Invalidate the entry.
  - Branch taken, hit, pred_pc==ex_target: correct. No update.
  - Branch taken, hit, pred_pc!=ex_target: mispredict. `redirect_pc`=ex_target. Overwrite target, valid=1.
  - Branch taken, miss: mispredict. `redirect_pc`=ex_target. Allocate, valid=1.
  - Branch not-taken, hit: mispredict. `redirect_pc`=pc4. Invalidate.
  - Branch not-taken, miss, or non-branch miss: correct. No update.
- `br_cnt` increments on each evaluated branch. `mis_cnt` increments on each mispredict. Both counters saturate at all-ones and never wrap.
- The update registers capture idx, tag, target and valid from EX.pc on a mispredict that requires a write.

## Timing

- Reset (asynchronous, `rst_n`=0) clears all slot v bits, `upd_we`, `upd_*`, `br_cnt` and `mis_cnt` to 0. `redirect`=0 while in reset.
- Prediction-to-resolution latency: exactly 2 unstalled cycles.
- `redirect` and `redirect_pc` are combinational from the EX slot and the `ex_*` inputs, so they are valid in the resolution cycle.
- `upd_we` is registered. It is asserted on the edge after the mispredict and lasts one cycle, independent of `stall`.
- A BTB lookup in the same cycle as `upd_we` sees the old entry. The BTB does not bypass.
- Stall and resolve in the same cycle: nothing is evaluated or counted; it is evaluated once stall drops. No double counting.
- A redirect in cycle N squashes the ID and EX slots at edge N. The IF instruction entering at N+1 is tracked normally.
- Back-to-back mispredicts in cycles N and N+3 both write the BTB. No update is lost.
- `rst_n` deasserted mid-stream: all in-flight slots are dropped. The first resolution occurs 2 cycles after the first valid IF.

## Structure

- Shared package `bp_pkg`:
  - `IDX_W` and the derived `TAG_W`.
  - Tracking-slot struct.
  - Update-request struct {we, idx, tag, target, valid}, shared with the BTB write port.
- One natural sub-module: `bp_track_slot`, a register for one slot with hold/flush/load, instantiated twice.
- Resolution compare and counters stay in the top level.

## Test plan

- Taken miss: branch at 0x0000_0040, not in BTB, taken to 0x0000_0100.
  - Redirect=1 and redirect_pc=0x100 two cycles after IF.
  - Next cycle: upd_we=1, idx=0x10, valid=1, target=0x100.
  - mis_cnt=1, br_cnt=1.
- Correct taken hit: same PC, hit with pred_pc=0x100, taken to 0x100.
  - No redirect, no upd_we.
  - br_cnt increments, mis_cnt does not.
- Target change: hit with pred_pc=0x100, resolved target 0x200.
  - redirect_pc=0x200.
  - upd_target=0x200.
- Not-taken hit at 0x40: redirect_pc=0x44, then upd_valid=0.
- Stall across resolution: EX holds a taken-miss branch with stall=1 for 3 cycles.
  - No redirect until stall=0, then exactly one redirect and one increment.
- Redirect squash, then reset mid-stream.
  - Mispredict in cycle N: the ID-slot hit at N+1 produces no resolution.
  - `rst_n` pulsed low: counters read 0 and upd_we=0 immediately (asynchronous).

Source files
------------

// File: rtl/bp_pkg.sv
// Branch-prediction shared package.
//   IDX_W / TAG_W : BTB index and tag widths (index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2])
//   track_slot_t  : one IF->ID->EX tracking slot {v, pc, hit, pred_pc}
//   upd_req_t     : BTB write-port request {we, idx, tag, target, valid}
package bp_pkg;

    localparam int IDX_W = 6;
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_pc;
    } track_slot_t;

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             valid;
    } upd_req_t;

endpackage

// File: rtl/bp_track_slot.sv
// One prediction tracking slot register.
//   clk, rst_n : clock, asynchronous active-low reset (clears the slot)
//   i_hold     : keep the current contents (pipeline stall)
//   i_flush    : squash the slot (v=0); wins over hold and load
//   i_d        : slot contents from the previous stage
//   o_q        : registered slot contents
module bp_track_slot
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hold,
    input  logic        i_flush,
    input  track_slot_t i_d,
    output track_slot_t o_q
);

    track_slot_t r_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q.v <= 1'b0;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/btb_update_unit.sv
// BTB resolution / update unit.
// Tracks each IF-stage BTB prediction through ID and EX, compares it with the
// branch outcome resolved in EX, raises a combinational redirect on a
// mispredict and issues a registered one-cycle BTB write.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_valid/if_pc/if_hit/if_pred_pc: prediction made in IF this cycle
//   stall                           : freezes the ID and EX tracking slots
//   ex_is_br/ex_taken/ex_target     : outcome of the instruction in EX
//   redirect/redirect_pc            : mispredict flush and correct next PC
//   upd_we/upd_idx/upd_tag/
//   upd_target/upd_valid            : registered BTB write request
//   br_cnt/mis_cnt                  : saturating branch / mispredict counters
module btb_update_unit
    import bp_pkg::track_slot_t;
#(
    parameter  int IDX_W = bp_pkg::IDX_W,
    parameter  int CNT_W = 32,
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_hit,
    input  logic [31:0]      if_pred_pc,
    input  logic             stall,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             upd_we,
    output logic [IDX_W-1:0] upd_idx,
    output logic [TAG_W-1:0] upd_tag,
    output logic [31:0]      upd_target,
    output logic             upd_valid,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    track_slot_t w_if;
    track_slot_t w_id;
    track_slot_t w_ex;

    assign w_if = '{v: if_valid, pc: if_pc, hit: if_hit, pred_pc: if_pred_pc};

    bp_track_slot u_id_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (stall),
        .i_flush (redirect),
        .i_d     (w_if),
        .o_q     (w_id)
    );

    bp_track_slot u_ex_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (stall),
        .i_flush (redirect),
        .i_d     (w_id),
        .o_q     (w_ex)
    );

    // A stalled EX instruction is resolved only once the stall drops, so it is
    // evaluated and counted exactly once.
    logic        w_eval;
    logic        w_mis;
    logic        w_new_valid;
    logic [31:0] w_pc4;
    logic [31:0] w_redirect_pc;

    assign w_eval = w_ex.v && !stall;
    assign w_pc4  = w_ex.pc + 32'd4;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_mis         = 1'b0;
        w_redirect_pc = w_pc4;
        w_new_valid   = 1'b0;
        if (w_eval) begin
            if (ex_is_br && ex_taken) begin
                // Taken: wrong unless the BTB hit with the exact target.
                w_redirect_pc = ex_target;
                w_new_valid   = 1'b1;
                w_mis         = !w_ex.hit || (w_ex.pred_pc != ex_target);
            end else begin
                // Not taken (or not a branch): any hit is a stale or aliased
                // entry that must be dropped.
                w_mis = w_ex.hit;
            end
        end
    end

    assign redirect    = w_mis;
    assign redirect_pc = w_redirect_pc;

    logic             r_upd_we;
    logic [IDX_W-1:0] r_upd_idx;
    logic [TAG_W-1:0] r_upd_tag;
    logic [31:0]      r_upd_target;
    logic             r_upd_valid;

    // The write strobe follows the mispredict by one edge regardless of stall;
    // the payload only reloads on a new mispredict. On an invalidate the
    // target field carries the fall-through PC, which the BTB ignores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_we     <= 1'b0;
            r_upd_idx    <= '0;
            r_upd_tag    <= '0;
            r_upd_target <= '0;
            r_upd_valid  <= 1'b0;
        end else begin
            r_upd_we <= w_mis;
            if (w_mis) begin
                r_upd_idx    <= w_ex.pc[IDX_W+1:2];
                r_upd_tag    <= w_ex.pc[31:IDX_W+2];
                r_upd_target <= w_redirect_pc;
                r_upd_valid  <= w_new_valid;
            end
        end
    end

    assign upd_we     = r_upd_we;
    assign upd_idx    = r_upd_idx;
    assign upd_tag    = r_upd_tag;
    assign upd_target = r_upd_target;
    assign upd_valid  = r_upd_valid;

    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    // Counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_eval && ex_is_br && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mis && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign br_cnt  = r_br_cnt;
    assign mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_btb_update_unit.sv
// Scoreboard bench for btb_update_unit: stimulus pushes expected redirect and
// BTB-write events (with the cycle they must appear in) into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents one.
module tb_btb_update_unit;

    localparam int IDX_W = 6;
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             if_hit;
    logic [31:0]      if_pred_pc;
    logic             stall;
    logic             ex_is_br;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             upd_we;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      upd_target;
    logic             upd_valid;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    btb_update_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_hit      (if_hit),
        .if_pred_pc  (if_pred_pc),
        .stall       (stall),
        .ex_is_br    (ex_is_br),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_we      (upd_we),
        .upd_idx     (upd_idx),
        .upd_tag     (upd_tag),
        .upd_target  (upd_target),
        .upd_valid   (upd_valid),
        .br_cnt      (br_cnt),
        .mis_cnt     (mis_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } rd_exp_t;

    typedef struct {
        int               cyc;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [31:0]      tgt;
        logic             v;
    } up_exp_t;

    rd_exp_t q_rd[$];
    up_exp_t q_up[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    // Monitor: compares every presented event against the queue heads and
    // flags expected events whose cycle passed without appearing.
    rd_exp_t m_rd;
    up_exp_t m_up;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
                fail_event("redirect_missing", $sformatf("got none, expected redirect_pc 0x%0h in cycle %0d", q_rd[0].pc, q_rd[0].cyc));
                void'(q_rd.pop_front());
            end
            while (q_up.size() > 0 && q_up[0].cyc < cyc) begin
                fail_event("upd_missing", $sformatf("got none, expected upd_we in cycle %0d", q_up[0].cyc));
                void'(q_up.pop_front());
            end
            if (redirect === 1'b1) begin
                if (q_rd.size() == 0) begin
                    fail_event("redirect_unexpected", $sformatf("got redirect=1 pc 0x%0h, expected redirect=0", redirect_pc));
                end else begin
                    m_rd = q_rd.pop_front();
                    check("redirect_cycle", 64'(cyc), 64'(m_rd.cyc));
                    check("redirect_pc", 64'(redirect_pc), 64'(m_rd.pc));
                end
            end
            if (upd_we === 1'b1) begin
                if (q_up.size() == 0) begin
                    fail_event("upd_unexpected", "got upd_we=1, expected upd_we=0");
                end else begin
                    m_up = q_up.pop_front();
                    check("upd_cycle", 64'(cyc), 64'(m_up.cyc));
                    check("upd_idx", 64'(upd_idx), 64'(m_up.idx));
                    check("upd_tag", 64'(upd_tag), 64'(m_up.tag));
                    check("upd_target", 64'(upd_target), 64'(m_up.tgt));
                    check("upd_valid", 64'(upd_valid), 64'(m_up.v));
                end
            end
        end
    end

    task automatic clear_ex();
        ex_is_br  = 1'b0;
        ex_taken  = 1'b0;
        ex_target = 32'h0;
    endtask

    task automatic check_counters();
        check("br_cnt", 64'(br_cnt), 64'(sat(exp_br)));
        check("mis_cnt", 64'(mis_cnt), 64'(sat(exp_mis)));
    endtask

    // One isolated instruction: IF in cycle c, EX outcome driven from c+2,
    // optionally held stalled for n_stall cycles. Expected values are given
    // by the caller.
    task automatic run_br(input logic [31:0] pc, input logic hit, input logic [31:0] pred,
                          input logic is_br, input logic taken, input logic [31:0] tgt,
                          input int n_stall, input logic e_mis, input logic [31:0] e_rpc,
                          input logic [IDX_W-1:0] e_idx, input logic [TAG_W-1:0] e_tag,
                          input logic e_v);
        int c;
        @(posedge clk); #1;
        c = cyc;
        if (e_mis) begin
            q_rd.push_back('{cyc: c + 2 + n_stall, pc: e_rpc});
            q_up.push_back('{cyc: c + 3 + n_stall, idx: e_idx, tag: e_tag, tgt: e_rpc, v: e_v});
        end
        if_valid = 1'b1; if_pc = pc; if_hit = hit; if_pred_pc = pred;
        @(posedge clk); #1;
        if_valid = 1'b0; if_hit = 1'b0;
        @(posedge clk); #1;
        ex_is_br = is_br; ex_taken = taken; ex_target = tgt;
        stall = (n_stall > 0);
        repeat (n_stall) begin
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(posedge clk); #1;
        clear_ex();
        exp_br  += int'(is_br);
        exp_mis += int'(e_mis);
        check_counters();
    endtask

    initial begin
        #200000;
        fail_event("watchdog", "got no end of stimulus, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        if_valid = 1'b0; if_pc = 32'h0; if_hit = 1'b0; if_pred_pc = 32'h0;
        stall = 1'b0;
        clear_ex();
        #1;
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_upd_we", 64'(upd_we), 64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_br_cnt", 64'(br_cnt), 64'd0);
        check("rst_mis_cnt", 64'(mis_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        //      pc            hit   pred          br    tk    tgt           st mis  rpc           idx    tag          v
        run_br(32'h0000_0040, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 0, 1'b1, 32'h0000_0100, 6'h10, 24'h0,      1'b1);
        run_br(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 0, 1'b0, 32'h0,        6'h00, 24'h0,      1'b0);
        run_br(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 0, 1'b1, 32'h0000_0200, 6'h10, 24'h0,      1'b1);
        run_br(32'h0000_0040, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200, 0, 1'b1, 32'h0000_0044, 6'h10, 24'h0,      1'b0);
        run_br(32'h1234_5678, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0,        0, 1'b1, 32'h1234_567C, 6'h1E, 24'h123456, 1'b0);
        run_br(32'h0000_0044, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        6'h00, 24'h0,      1'b0);
        run_br(32'h0000_0048, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0900, 0, 1'b0, 32'h0,        6'h00, 24'h0,      1'b0);
        run_br(32'h0000_0080, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0300, 3, 1'b1, 32'h0000_0300, 6'h20, 24'h0,      1'b1);

        // Redirect squash: A mispredicts in N=c+2, B (aliased hit) is squashed
        // in ID, C enters IF at N+1 and mispredicts at N+3.
        @(posedge clk); #1;
        c = cyc;
        q_rd.push_back('{cyc: c + 2, pc: 32'h0000_0400});
        q_up.push_back('{cyc: c + 3, idx: 6'h00, tag: 24'h000001, tgt: 32'h0000_0400, v: 1'b1});
        if_valid = 1'b1; if_pc = 32'h0000_0100; if_hit = 1'b0; if_pred_pc = 32'h0;
        @(posedge clk); #1;
        if_pc = 32'h0000_0104; if_hit = 1'b1; if_pred_pc = 32'h0000_0500;
        @(posedge clk); #1;
        if_valid = 1'b0; if_hit = 1'b0;
        ex_is_br = 1'b1; ex_taken = 1'b1; ex_target = 32'h0000_0400;
        @(posedge clk); #1;
        q_rd.push_back('{cyc: c + 5, pc: 32'h0000_0600});
        q_up.push_back('{cyc: c + 6, idx: 6'h00, tag: 24'h000002, tgt: 32'h0000_0600, v: 1'b1});
        if_valid = 1'b1; if_pc = 32'h0000_0200; if_hit = 1'b0;
        clear_ex();
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(posedge clk); #1;
        ex_is_br = 1'b1; ex_taken = 1'b1; ex_target = 32'h0000_0600;
        @(posedge clk); #1;
        clear_ex();
        exp_br  += 2;
        exp_mis += 2;
        check_counters();

        // Drive both counters past all-ones.
        for (int k = 0; k < 10; k++) begin
            run_br(32'h0000_1000 + 32'(4 * k), 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000 + 32'(16 * k), 0,
                   1'b1, 32'h0000_2000 + 32'(16 * k), 6'(k), 24'h000010, 1'b1);
        end

        // Asynchronous reset while upd_we is high.
        @(posedge clk); #1;
        c = cyc;
        q_rd.push_back('{cyc: c + 2, pc: 32'h0000_0800});
        if_valid = 1'b1; if_pc = 32'h0000_0500; if_hit = 1'b0;
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(posedge clk); #1;
        ex_is_br = 1'b1; ex_taken = 1'b1; ex_target = 32'h0000_0800;
        @(posedge clk); #1;
        clear_ex();
        check("upd_we_before_reset", 64'(upd_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        exp_br  = 0;
        exp_mis = 0;
        check("async_upd_we", 64'(upd_we), 64'd0);
        check("async_redirect", 64'(redirect), 64'd0);
        check("async_upd_valid", 64'(upd_valid), 64'd0);
        check_counters();
        #1 rst_n = 1'b1;

        // Reset while an aliased hit sits in ID: it must never resolve.
        @(posedge clk); #1;
        if_valid = 1'b1; if_pc = 32'h0000_0600; if_hit = 1'b1; if_pred_pc = 32'h0000_0900;
        @(posedge clk); #1;
        if_valid = 1'b0; if_hit = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ex_is_br = 1'b0;
        @(posedge clk); #1;
        check_counters();

        // First prediction after reset resolves 2 cycles after IF.
        run_br(32'h0000_0700, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0A00, 0, 1'b1, 32'h0000_0A00, 6'h00, 24'h000007, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("redirect_queue_drained", 64'(q_rd.size()), 64'd0);
        check("upd_queue_drained", 64'(q_up.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
